scan_ctr_regs: RTL and testbench
================================

Name: scan_ctr_regs

Overview:
- Responder for the scan control-register path: the endpoint behind the mem/reg mux's ctr_ren/ctr_wen/ctr*_wdata/ctr*_rdata/ctr_ready interface.
- Holds the 17-bit ctr1 and 15-bit ctr2 configuration registers.
- Answers scan reads and writes with a single-cycle ctr_ready pulse after a fixed latency.
- Drives the register contents to the core as configuration outputs.

Parameters:
- LATENCY, 1, response latency in cycles; legal range 1..15.
- CTR1_RST, 17'h0, reset value of ctr1.
- CTR2_RST, 15'h0, reset value of ctr2.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous reset, active-low
- ctr_ren  input  1  read request (level)
- ctr_wen  input  1  write request (level)
- ctr1_wdata  input  17  write data for ctr1 (scan_wdata[31:15])
- ctr2_wdata  input  15  write data for ctr2 (scan_wdata[14:0])
- ctr1_rdata  output  17  read data for ctr1
- ctr2_rdata  output  15  read data for ctr2
- ctr_ready  output  1  one-cycle completion pulse
- cfg_ctr1  output  17  ctr1 value driven to the core
- cfg_ctr2  output  15  ctr2 value driven to the core
- cfg_update  output  1  one-cycle pulse when cfg_ctr1/cfg_ctr2 change
- cfg_commit  input  1  shadow commit strobe; used only with the optional feature, otherwise ignored

Behaviour:
- Reset (rst_n low, asynchronous) sets the following; any in-flight request is discarded:
  - state = IDLE, counter = 0
  - ctr1 = CTR1_RST, ctr2 = CTR2_RST
  - ctr1_rdata = 0, ctr2_rdata = 0
  - ctr_ready = 0, cfg_update = 0
  - cfg_ctr1 = CTR1_RST, cfg_ctr2 = CTR2_RST
- States: IDLE, WAIT, DONE, HOLD.
- IDLE:
  - A rising edge with ctr_ren or ctr_wen high accepts the request. This is acceptance edge 1.
  - Latch the operation: write if ctr_wen=1 (write wins if both are high), else read.
  - Latch ctr1_wdata and ctr2_wdata at this edge.
  - If LATENCY=1, go directly to DONE; otherwise go to WAIT with counter=1.
- WAIT:
  - Increment counter each edge.
  - When counter reaches LATENCY-1, the next edge goes to DONE.
  - Enables are ignored while in WAIT. A request dropped mid-WAIT still completes.
- DONE is entered on the LATENCY-th edge counted from acceptance. On that entering edge:
  - ctr_ready = 1 for exactly one cycle.
  - Write: ctr1/ctr2 take the latched wdata. ctr1_rdata/ctr2_rdata show the new values in the same cycle ctr_ready is high. cfg_update pulses in the same cycle as ctr_ready.
  - Read: ctr1_rdata/ctr2_rdata are loaded with the current ctr1/ctr2.
  - Next edge goes to HOLD.
- HOLD:
  - Stay until ctr_ren=0 and ctr_wen=0 are sampled, then go to IDLE.
  - This stops a level-held enable from being accepted twice.
  - A new request is only accepted from IDLE, so the minimum spacing between requests is one cycle with both enables low.
- ctr1_rdata/ctr2_rdata hold their value until the next DONE. They are never cleared except by reset.
- ctr_ready is never high outside DONE.
- Without the optional feature, cfg_ctr1/cfg_ctr2 equal ctr1/ctr2 (registered, same edge).

Optional Feature:
- Macro: SCAN_CTR_SHADOW_EN.
- Defined:
  - ctr1/ctr2 act as shadow registers; scan writes and reads access the shadow.
  - cfg_ctr1/cfg_ctr2 load the shadow on a clock edge where cfg_commit=1. cfg_update pulses on the cycle after that edge.
  - A commit coinciding with a DONE write commits the new value.
  - Scan writes alone do not pulse cfg_update.
- Undefined: cfg_commit is ignored; behaviour is as above.

Test Plan:
- Reset values: reset release, LATENCY=1 -> cfg_ctr1=17'h0, cfg_ctr2=15'h0, ctr_ready=0, rdata=0.
- Write then read: ctr_wen=1 with wdata {17'h1ABCD, 15'h2345}, held 3 cycles -> exactly one ctr_ready pulse, 1 cycle after acceptance; cfg_ctr1=17'h1ABCD, cfg_ctr2=15'h2345; cfg_update pulses once. Then drop wen, raise ctr_ren -> one ready pulse with rdata={17'h1ABCD, 15'h2345}.
- Latency: LATENCY=4, read request -> ctr_ready rises on the 4th edge from acceptance. Repeat with ctr_ren dropped after 1 cycle -> ready still occurs.
- Simultaneous ren and wen, data 32'hFFFF_FFFF -> treated as a write; ctr1=17'h1FFFF, ctr2=15'h7FFF, rdata matches in the ready cycle.
- Reset mid-op: LATENCY=8, write accepted, rst_n pulsed low at counter=3 -> no ctr_ready; registers stay at CTR1_RST/CTR2_RST; next request behaves normally.
- SCAN_CTR_SHADOW_EN: write 17'h00055/15'h0011 -> cfg outputs unchanged and no cfg_update. Then cfg_commit=1 for one cycle -> cfg outputs update, cfg_update pulses once on the next cycle.

Source files
------------

// File: rtl/scan_ctr_regs.sv
// Scan control-register responder: holds ctr1/ctr2 and answers scan accesses with a
// single-cycle ctr_ready after LATENCY edges. Define SCAN_CTR_SHADOW_EN to make ctr1/ctr2
// shadow registers that reach the core only on cfg_commit.
module scan_ctr_regs #(
    parameter int unsigned LATENCY  = 1,
    parameter logic [16:0] CTR1_RST = 17'h0,
    parameter logic [14:0] CTR2_RST = 15'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ctr_ren,
    input  logic        ctr_wen,
    input  logic [16:0] ctr1_wdata,
    input  logic [14:0] ctr2_wdata,
    output logic [16:0] ctr1_rdata,
    output logic [14:0] ctr2_rdata,
    output logic        ctr_ready,
    output logic [16:0] cfg_ctr1,
    output logic [14:0] cfg_ctr2,
    output logic        cfg_update,
    input  logic        cfg_commit
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE,
        HOLD
    } state_t;

    localparam logic [3:0] LAST_WAIT = 4'(LATENCY - 1);

    state_t      state;
    state_t      next_state;
    logic [3:0]  counter;
    logic        op_wr;
    logic [16:0] wdata1_q;
    logic [14:0] wdata2_q;
    logic [16:0] ctr1;
    logic [14:0] ctr2;

    logic        accept;
    logic        enter_done;
    logic        done_wr;
    logic [16:0] done_wdata1;
    logic [14:0] done_wdata2;

    // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (ctr_ren || ctr_wen) begin
                    next_state = (LATENCY == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (counter == LAST_WAIT) begin
                    next_state = DONE;
                end
            end
            DONE: next_state = HOLD;
            HOLD: begin
                if (!ctr_ren && !ctr_wen) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // With LATENCY=1 the DONE-entering edge is the acceptance edge, so the live inputs apply.
    always_comb begin
        ctr_ready   = (state == DONE);
        accept      = (state == IDLE) && (ctr_ren || ctr_wen);
        enter_done  = (next_state == DONE);
        done_wr     = accept ? ctr_wen    : op_wr;
        done_wdata1 = accept ? ctr1_wdata : wdata1_q;
        done_wdata2 = accept ? ctr2_wdata : wdata2_q;
    end

    // NOTE: every flop here, data included, is async-reset so an aborted request leaves no residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter  <= '0;
            op_wr    <= 1'b0;
            wdata1_q <= '0;
            wdata2_q <= '0;
        end else if (accept) begin
            counter  <= 4'd1;
            op_wr    <= ctr_wen;
            wdata1_q <= ctr1_wdata;
            wdata2_q <= ctr2_wdata;
        end else if (state == WAIT) begin
            counter <= counter + 4'd1;
        end
    end

    // rdata only changes on entry to DONE and otherwise holds until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr1       <= CTR1_RST;
            ctr2       <= CTR2_RST;
            ctr1_rdata <= '0;
            ctr2_rdata <= '0;
        end else if (enter_done) begin
            if (done_wr) begin
                ctr1       <= done_wdata1;
                ctr2       <= done_wdata2;
                ctr1_rdata <= done_wdata1;
                ctr2_rdata <= done_wdata2;
            end else begin
                ctr1_rdata <= ctr1;
                ctr2_rdata <= ctr2;
            end
        end
    end

`ifdef SCAN_CTR_SHADOW_EN
    // A commit on the same edge as a DONE write forwards the value being written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ctr1   <= CTR1_RST;
            cfg_ctr2   <= CTR2_RST;
            cfg_update <= 1'b0;
        end else begin
            cfg_update <= cfg_commit;
            if (cfg_commit) begin
                cfg_ctr1 <= (enter_done && done_wr) ? done_wdata1 : ctr1;
                cfg_ctr2 <= (enter_done && done_wr) ? done_wdata2 : ctr2;
            end
        end
    end
`else
    logic unused_cfg_commit;
    assign unused_cfg_commit = cfg_commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ctr1   <= CTR1_RST;
            cfg_ctr2   <= CTR2_RST;
            cfg_update <= 1'b0;
        end else begin
            cfg_update <= enter_done && done_wr;
            if (enter_done && done_wr) begin
                cfg_ctr1 <= done_wdata1;
                cfg_ctr2 <= done_wdata2;
            end
        end
    end
`endif

endmodule

// File: tb/tb_scan_ctr_regs.sv
// Self-checking bench for scan_ctr_regs: three instances (LATENCY 1/4/8) driven by directed
// and random scan transactions, compared each cycle against a transaction-level model.
module tb_scan_ctr_regs;

`ifdef SCAN_CTR_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    localparam logic [16:0] K2_CTR1_RST = 17'h0A5A5;
    localparam logic [14:0] K2_CTR2_RST = 15'h1234;

    logic        clk = 1'b0;
    logic        rst_n      [3];
    logic        ren        [3];
    logic        wen        [3];
    logic [16:0] wd1        [3];
    logic [14:0] wd2        [3];
    logic        cfg_commit [3];
    logic [16:0] rd1        [3];
    logic [14:0] rd2        [3];
    logic        ready      [3];
    logic [16:0] cfg1       [3];
    logic [14:0] cfg2       [3];
    logic        upd        [3];

    // Reference model: architectural register contents per instance.
    logic [16:0] m_ctr1 [3];
    logic [14:0] m_ctr2 [3];
    logic [16:0] m_rd1  [3];
    logic [14:0] m_rd2  [3];
    logic [16:0] m_cfg1 [3];
    logic [14:0] m_cfg2 [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scan_ctr_regs #(.LATENCY(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .ctr_ren(ren[0]), .ctr_wen(wen[0]),
        .ctr1_wdata(wd1[0]), .ctr2_wdata(wd2[0]), .ctr1_rdata(rd1[0]), .ctr2_rdata(rd2[0]),
        .ctr_ready(ready[0]), .cfg_ctr1(cfg1[0]), .cfg_ctr2(cfg2[0]), .cfg_update(upd[0]),
        .cfg_commit(cfg_commit[0])
    );

    scan_ctr_regs #(.LATENCY(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .ctr_ren(ren[1]), .ctr_wen(wen[1]),
        .ctr1_wdata(wd1[1]), .ctr2_wdata(wd2[1]), .ctr1_rdata(rd1[1]), .ctr2_rdata(rd2[1]),
        .ctr_ready(ready[1]), .cfg_ctr1(cfg1[1]), .cfg_ctr2(cfg2[1]), .cfg_update(upd[1]),
        .cfg_commit(cfg_commit[1])
    );

    scan_ctr_regs #(.LATENCY(8), .CTR1_RST(K2_CTR1_RST), .CTR2_RST(K2_CTR2_RST)) u_dut2 (
        .clk(clk), .rst_n(rst_n[2]), .ctr_ren(ren[2]), .ctr_wen(wen[2]),
        .ctr1_wdata(wd1[2]), .ctr2_wdata(wd2[2]), .ctr1_rdata(rd1[2]), .ctr2_rdata(rd2[2]),
        .ctr_ready(ready[2]), .cfg_ctr1(cfg1[2]), .cfg_ctr2(cfg2[2]), .cfg_update(upd[2]),
        .cfg_commit(cfg_commit[2])
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 4 : 8;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m_ctr1[k] = (k == 2) ? K2_CTR1_RST : 17'h0;
        m_ctr2[k] = (k == 2) ? K2_CTR2_RST : 15'h0;
        m_rd1[k]  = '0;
        m_rd2[k]  = '0;
        m_cfg1[k] = m_ctr1[k];
        m_cfg2[k] = m_ctr2[k];
    endtask

    task automatic check_outputs(input int k, input bit exp_ready, input bit exp_upd);
        check($sformatf("u%0d ctr_ready", k), 32'(ready[k]), 32'(exp_ready));
        check($sformatf("u%0d cfg_update", k), 32'(upd[k]), 32'(exp_upd));
        check($sformatf("u%0d ctr1_rdata", k), 32'(rd1[k]), 32'(m_rd1[k]));
        check($sformatf("u%0d ctr2_rdata", k), 32'(rd2[k]), 32'(m_rd2[k]));
        check($sformatf("u%0d cfg_ctr1", k), 32'(cfg1[k]), 32'(m_cfg1[k]));
        check($sformatf("u%0d cfg_ctr2", k), 32'(cfg2[k]), 32'(m_cfg2[k]));
    endtask

    // Called at a negedge with the instance idle. Enables stay high across `hold` edges;
    // wdata is scrambled after acceptance to prove it was captured at the acceptance edge.
    task automatic txn(input int k, input bit do_wr, input bit do_rd,
                       input logic [16:0] d1, input logic [14:0] d2, input int hold);
        int lat  = lat_of(k);
        int last = ((hold > lat) ? hold : lat) + 3;
        wen[k] = do_wr;
        ren[k] = do_rd;
        wd1[k] = d1;
        wd2[k] = d2;
        for (int i = 1; i <= last; i++) begin
            @(negedge clk);
            if (i == lat) begin
                if (do_wr) begin
                    m_ctr1[k] = d1;
                    m_ctr2[k] = d2;
                    m_rd1[k]  = d1;
                    m_rd2[k]  = d2;
                    if (!SHADOW) begin
                        m_cfg1[k] = d1;
                        m_cfg2[k] = d2;
                    end
                end else begin
                    m_rd1[k] = m_ctr1[k];
                    m_rd2[k] = m_ctr2[k];
                end
            end
            check_outputs(k, i == lat, (i == lat) && do_wr && !SHADOW);
            if (i >= hold) begin
                ren[k] = 1'b0;
                wen[k] = 1'b0;
            end
            wd1[k] = 17'($urandom);
            wd2[k] = 15'($urandom);
            cfg_commit[k] = SHADOW ? 1'b0 : 1'($urandom);
        end
        cfg_commit[k] = 1'b0;
    endtask

    task automatic commit(input int k);
        cfg_commit[k] = 1'b1;
        @(negedge clk);
        cfg_commit[k] = 1'b0;
        if (SHADOW) begin
            m_cfg1[k] = m_ctr1[k];
            m_cfg2[k] = m_ctr2[k];
        end
        check_outputs(k, 1'b0, SHADOW);
        @(negedge clk);
        check_outputs(k, 1'b0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0;
            ren[k] = 1'b0;
            wen[k] = 1'b0;
            wd1[k] = '0;
            wd2[k] = '0;
            cfg_commit[k] = 1'b0;
            model_reset(k);
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_outputs(k, 1'b0, 1'b0);

        // Write held for 3 cycles, then read it back; then write with both enables high.
        txn(0, 1'b1, 1'b0, 17'h1ABCD, 15'h2345, 3);
        txn(0, 1'b0, 1'b1, 17'h00000, 15'h0000, 1);
        txn(0, 1'b1, 1'b1, 17'h1FFFF, 15'h7FFF, 1);
        txn(0, 1'b0, 1'b1, 17'h00000, 15'h0000, 2);

        // LATENCY=4: read held past completion, then read dropped after one cycle.
        txn(1, 1'b1, 1'b0, 17'h0F0F0, 15'h5555, 2);
        txn(1, 1'b0, 1'b1, 17'h00000, 15'h0000, 6);
        txn(1, 1'b0, 1'b1, 17'h00000, 15'h0000, 1);

        // LATENCY=8: reset pulsed while the write is waiting at counter=3.
        wen[2] = 1'b1;
        wd1[2] = 17'h13579;
        wd2[2] = 15'h2468;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check_outputs(2, 1'b0, 1'b0);
        end
        rst_n[2] = 1'b0;
        wen[2] = 1'b0;
        #2;
        model_reset(2);
        check_outputs(2, 1'b0, 1'b0);
        rst_n[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_outputs(2, 1'b0, 1'b0);
        end
        txn(2, 1'b1, 1'b0, 17'h0BEEF, 15'h0ACE, 2);
        txn(2, 1'b0, 1'b1, 17'h00000, 15'h0000, 1);

        // Shadow: the write stays off the core until the commit strobe.
        txn(0, 1'b1, 1'b0, 17'h00055, 15'h0011, 1);
        commit(0);

        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 25; n++) begin
                int op = int'($urandom_range(0, 2));
                txn(k, op != 0, op != 1, 17'($urandom), 15'($urandom),
                    int'($urandom_range(1, lat_of(k) + 3)));
                if ($urandom_range(0, 3) == 0) commit(k);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
